// File: rtl/instr_loader.sv
// Boot loader: receives a byte-stream program image, writes it word by word into the
// instruction store, zero-fills the tail and releases the CPU once the checksum matches.
module instr_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_data_i,
   output logic          byte_ready_o,
   output logic          im_we_o,
   output logic [AW-1:0] im_addr_o,
   output logic [31:0]   im_wdata_o,
   output logic          cpu_rst_n_o,
   output logic          done_o,
   output logic          err_o
);

   localparam int AW1 = AW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_CKSUM = 3'd3;
   localparam logic [2:0] S_FILL  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam logic [AW:0] DEPTH_W = AW1'(DEPTH);
   localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

   logic [2:0]  state;
   logic [AW:0] n_words;
   logic [AW:0] word_cnt;
   logic [AW:0] word_next;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_word;
   logic [31:0] acc;
   logic [31:0] full_word;
   logic        fire;

   assign byte_ready_o = (state == S_HDR) || (state == S_DATA) || (state == S_CKSUM);
   assign fire         = byte_valid_i && byte_ready_o;
   assign full_word    = {byte_data_i, asm_word};
   assign word_next    = word_cnt + 1'b1;

   // Little-endian byte assembly shared by data words and the checksum word.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         asm_word <= '0;
      end else if (fire && state == S_HDR) begin
         byte_cnt <= '0;
      end else if (fire) begin
         byte_cnt <= byte_cnt + 1'b1;
         case (byte_cnt)
            2'd0:    asm_word[7:0]   <= byte_data_i;
            2'd1:    asm_word[15:8]  <= byte_data_i;
            2'd2:    asm_word[23:16] <= byte_data_i;
            default: asm_word        <= asm_word;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         n_words     <= '0;
         word_cnt    <= '0;
         acc         <= '0;
         im_we_o     <= 1'b0;
         im_addr_o   <= '0;
         im_wdata_o  <= '0;
         cpu_rst_n_o <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         im_we_o <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state       <= S_HDR;
                  done_o      <= 1'b0;
                  err_o       <= 1'b0;
                  cpu_rst_n_o <= 1'b0;
               end
            end
            S_HDR: begin
               if (fire) begin
                  if (byte_data_i != 8'd0 && byte_data_i <= DEPTH_B) begin
                     state    <= S_DATA;
                     n_words  <= byte_data_i[AW:0];
                     word_cnt <= '0;
                     acc      <= '0;
                  end else begin
                     state <= S_ERR;
                     err_o <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (fire && byte_cnt == 2'd3) begin
                  im_we_o    <= 1'b1;
                  im_addr_o  <= word_cnt[AW-1:0];
                  im_wdata_o <= full_word;
                  acc        <= acc ^ full_word;
                  word_cnt   <= word_next;
                  if (word_next == n_words) begin
                     state <= S_CKSUM;
                  end
               end
            end
            // The first fill write is issued together with the checksum verdict.
            S_CKSUM: begin
               if (fire && byte_cnt == 2'd3) begin
                  if (full_word != acc) begin
                     state <= S_ERR;
                     err_o <= 1'b1;
                  end else if (n_words == DEPTH_W) begin
                     state       <= S_DONE;
                     done_o      <= 1'b1;
                     cpu_rst_n_o <= 1'b1;
                  end else begin
                     state      <= S_FILL;
                     im_we_o    <= 1'b1;
                     im_addr_o  <= word_cnt[AW-1:0];
                     im_wdata_o <= '0;
                     word_cnt   <= word_next;
                  end
               end
            end
            S_FILL: begin
               if (word_cnt == DEPTH_W) begin
                  state       <= S_DONE;
                  done_o      <= 1'b1;
                  cpu_rst_n_o <= 1'b1;
               end else begin
                  im_we_o    <= 1'b1;
                  im_addr_o  <= word_cnt[AW-1:0];
                  im_wdata_o <= '0;
                  word_cnt   <= word_next;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: streams directed and random images and compares
// the observed memory writes, flags and their timing against a behavioural image model.
module tb_instr_loader;

   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk_i = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          byte_valid_i = 1'b0;
   logic [7:0]    byte_data_i = 8'h00;
   logic          byte_ready_o;
   logic          im_we_o;
   logic [AW-1:0] im_addr_o;
   logic [31:0]   im_wdata_o;
   logic          cpu_rst_n_o;
   logic          done_o;
   logic          err_o;

   instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .im_we_o      (im_we_o),
      .im_addr_o    (im_addr_o),
      .im_wdata_o   (im_wdata_o),
      .cpu_rst_n_o  (cpu_rst_n_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Observed writes and flag rise times, stamped with the edge that registered them.
   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wr_cyc_q[$];
   int          done_cyc = -1;
   int          err_cyc = -1;

   always @(negedge clk_i) begin
      if (im_we_o === 1'b1) begin
         wr_addr_q.push_back(int'(im_addr_o));
         wr_data_q.push_back(im_wdata_o);
         wr_cyc_q.push_back(cyc);
      end
      if (done_o === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
   end

   // Image under test and the expectations derived from it.
   logic [31:0] img[DEPTH];
   int          img_n;
   logic [31:0] img_cks;
   int          acc_cyc[DEPTH];
   int          last_cyc;
   int          stall_cnt;
   int          exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int          exp_cyc_q[$];
   bit          exp_ok;
   int          exp_end_cyc;

   task automatic clear_monitor();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cyc = -1;
      err_cyc = -1;
   endtask

   task automatic random_image(input int n, input bit corrupt);
      logic [31:0] x;
      x = 32'h0;
      img_n = n;
      for (int k = 0; k < DEPTH; k++) img[k] = $urandom;
      for (int k = 0; k < n; k++) x = x ^ img[k];
      img_cks = corrupt ? (x ^ (32'h1 << $urandom_range(0, 31))) : x;
   endtask

   task automatic build_expected();
      logic [31:0] x;
      x = 32'h0;
      for (int k = 0; k < img_n; k++) x = x ^ img[k];
      exp_ok = (x == img_cks);
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_cyc_q.delete();
      for (int k = 0; k < img_n; k++) begin
         exp_addr_q.push_back(k);
         exp_data_q.push_back(img[k]);
         exp_cyc_q.push_back(acc_cyc[k]);
      end
      if (exp_ok) begin
         for (int k = img_n; k < DEPTH; k++) begin
            exp_addr_q.push_back(k);
            exp_data_q.push_back(32'h0);
            exp_cyc_q.push_back(last_cyc + (k - img_n));
         end
      end
      exp_end_cyc = exp_ok ? last_cyc + (DEPTH - img_n) : last_cyc;
   endtask

   task automatic start_load();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      byte_valid_i = 1'b1;
      byte_data_i = b;
      @(negedge clk_i);
      while (byte_ready_o !== 1'b1 && guard < 20) begin
         @(negedge clk_i);
         guard++;
      end
      stall_cnt += guard;
      if (byte_ready_o !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL byte_accept: byte_ready_o=%b after %0d cycles, required 1", byte_ready_o, guard);
      end
      @(posedge clk_i); #1;
      last_cyc = cyc;
      byte_valid_i = 1'b0;
   endtask

   task automatic gap_cycle(input bit poke);
      byte_valid_i = 1'b0;
      byte_data_i = 8'($urandom);
      start_i = poke;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic stream_image(input bit gapped, input int poke_at);
      start_load();
      clear_monitor();
      stall_cnt = 0;
      put_byte(img_n[7:0]);
      if (gapped) gap_cycle(1'b0);
      for (int k = 0; k < img_n; k++) begin
         for (int b = 0; b < 4; b++) begin
            put_byte(img[k][8*b +: 8]);
            if (b == 3) acc_cyc[k] = last_cyc;
            if (gapped) gap_cycle(k * 4 + b == poke_at);
         end
      end
      for (int b = 0; b < 4; b++) begin
         put_byte(img_cks[8*b +: 8]);
         if (gapped && b < 3) gap_cycle(1'b0);
      end
      build_expected();
   endtask

   task automatic wait_end();
      int guard;
      guard = 0;
      @(negedge clk_i);
      while (done_o !== 1'b1 && err_o !== 1'b1 && guard < 200) begin
         @(negedge clk_i);
         guard++;
      end
      if (done_o !== 1'b1 && err_o !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL load_timeout: done_o=%b err_o=%b, required one of them high", done_o, err_o);
      end
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({byte_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_values: rdy=%b we=%b addr=%0d data=%h cpu_rst_n=%b done=%b err=%b, required all 0",
                  byte_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o);
      end
      repeat (2) @(posedge clk_i);
      #3 rst_n = 1'b1;
      @(posedge clk_i); #1;
      byte_valid_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (byte_ready_o !== 1'b0 || im_we_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_ignores_bytes: rdy=%b we=%b, required 0 0", byte_ready_o, im_we_o);
      end
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic test_two_word();
      img_n = 2;
      img[0] = 32'h4C000001;
      img[1] = 32'h00221820;
      img_cks = 32'h4C000001 ^ 32'h00221820;
      stream_image(1'b0, -1);
      wait_end();
      vectors++;
      if (wr_addr_q.size() !== exp_addr_q.size()) begin
         miscompares++;
         $display("[TB] FAIL two_word write_count: got %0d, required %0d", wr_addr_q.size(), exp_addr_q.size());
      end
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         vectors++;
         if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
            miscompares++;
            $display("[TB] FAIL two_word write %0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                     i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
         end
      end
      vectors++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || cpu_rst_n_o !== 1'b1 || done_cyc !== exp_end_cyc) begin
         miscompares++;
         $display("[TB] FAIL two_word done: done=%b err=%b cpu_rst_n=%b at cyc %0d, required 1 0 1 at cyc %0d",
                  done_o, err_o, cpu_rst_n_o, done_cyc, exp_end_cyc);
      end
      byte_valid_i = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         vectors++;
         if (byte_ready_o !== 1'b0 || done_o !== 1'b1 || wr_addr_q.size() !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL done_ignores_bytes: rdy=%b done=%b writes=%0d, required 0 1 %0d",
                     byte_ready_o, done_o, wr_addr_q.size(), DEPTH);
         end
      end
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic test_full_image();
      img_n = DEPTH;
      img_cks = 32'h0;
      for (int k = 0; k < DEPTH; k++) begin
         img[k] = k * 32'h01010101;
         img_cks = img_cks ^ img[k];
      end
      stream_image(1'b0, -1);
      wait_end();
      vectors++;
      if (wr_addr_q.size() !== DEPTH || stall_cnt !== 0) begin
         miscompares++;
         $display("[TB] FAIL full_image shape: writes %0d stalls %0d, required %0d and 0", wr_addr_q.size(), stall_cnt, DEPTH);
      end
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         vectors++;
         if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
            miscompares++;
            $display("[TB] FAIL full_image write %0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                     i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
         end
      end
      vectors++;
      if (done_o !== 1'b1 || cpu_rst_n_o !== 1'b1 || err_o !== 1'b0 || done_cyc !== last_cyc) begin
         miscompares++;
         $display("[TB] FAIL full_image done: done=%b cpu_rst_n=%b err=%b at cyc %0d, required 1 1 0 at cyc %0d",
                  done_o, cpu_rst_n_o, err_o, done_cyc, last_cyc);
      end
   endtask

   task automatic test_cksum_error();
      img_n = 1;
      img[0] = 32'h12345678;
      img_cks = 32'h12345679;
      stream_image(1'b0, -1);
      wait_end();
      vectors++;
      if (wr_addr_q.size() !== 1) begin
         miscompares++;
         $display("[TB] FAIL cksum_error write_count: got %0d, required 1", wr_addr_q.size());
      end else begin
         vectors++;
         if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'h12345678) begin
            miscompares++;
            $display("[TB] FAIL cksum_error write: got addr %0d data %h, required addr 0 data 12345678",
                     wr_addr_q[0], wr_data_q[0]);
         end
      end
      vectors++;
      if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0 || err_cyc !== exp_end_cyc) begin
         miscompares++;
         $display("[TB] FAIL cksum_error flags: err=%b done=%b cpu_rst_n=%b at cyc %0d, required 1 0 0 at cyc %0d",
                  err_o, done_o, cpu_rst_n_o, err_cyc, exp_end_cyc);
      end
      random_image(2, 1'b0);
      stream_image(1'b0, -1);
      wait_end();
      vectors++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || cpu_rst_n_o !== 1'b1 || wr_addr_q.size() !== DEPTH) begin
         miscompares++;
         $display("[TB] FAIL cksum_recover: done=%b err=%b cpu_rst_n=%b writes=%0d, required 1 0 1 %0d",
                  done_o, err_o, cpu_rst_n_o, wr_addr_q.size(), DEPTH);
      end
   endtask

   task automatic test_bad_header();
      int hdrs[3];
      int h;
      hdrs[0] = 0;
      hdrs[1] = DEPTH + 1;
      hdrs[2] = $urandom_range(DEPTH + 2, 255);
      foreach (hdrs[i]) begin
         start_load();
         clear_monitor();
         put_byte(hdrs[i][7:0]);
         h = last_cyc;
         repeat (2) @(posedge clk_i);
         #1;
         vectors++;
         if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0 || err_cyc !== h || wr_addr_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL bad_header %0d: err=%b done=%b cpu_rst_n=%b err_cyc=%0d writes=%0d, required 1 0 0 %0d 0",
                     hdrs[i], err_o, done_o, cpu_rst_n_o, err_cyc, wr_addr_q.size(), h);
         end
      end
   endtask

   task automatic test_gapped();
      random_image(3, 1'b0);
      stream_image(1'b1, 6);
      wait_end();
      vectors++;
      if (wr_addr_q.size() !== exp_addr_q.size()) begin
         miscompares++;
         $display("[TB] FAIL gapped write_count: got %0d, required %0d", wr_addr_q.size(), exp_addr_q.size());
      end
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         vectors++;
         if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
            miscompares++;
            $display("[TB] FAIL gapped write %0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                     i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
         end
      end
      vectors++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || done_cyc !== exp_end_cyc) begin
         miscompares++;
         $display("[TB] FAIL gapped done: done=%b err=%b at cyc %0d, required 1 0 at cyc %0d",
                  done_o, err_o, done_cyc, exp_end_cyc);
      end
   endtask

   task automatic test_reset_mid_data();
      random_image(3, 1'b0);
      img[0] = img[0] | 32'h1;
      start_load();
      put_byte(8'd3);
      for (int b = 0; b < 5; b++) put_byte(img[b / 4][8*(b % 4) +: 8]);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({byte_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_values: rdy=%b we=%b addr=%0d data=%h cpu_rst_n=%b done=%b err=%b, required all 0",
                  byte_ready_o, im_we_o, im_addr_o, im_wdata_o, cpu_rst_n_o, done_o, err_o);
      end
      @(posedge clk_i);
      #3 rst_n = 1'b1;
      @(posedge clk_i); #1;
      vectors++;
      if (byte_ready_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_idle: rdy=%b cpu_rst_n=%b, required 0 0", byte_ready_o, cpu_rst_n_o);
      end
      random_image($urandom_range(1, DEPTH), 1'b0);
      stream_image(1'b0, -1);
      wait_end();
      vectors++;
      if (wr_addr_q.size() !== exp_addr_q.size()) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_reload write_count: got %0d, required %0d", wr_addr_q.size(), exp_addr_q.size());
      end
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         vectors++;
         if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_reload write %0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                     i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
         end
      end
      vectors++;
      if (done_o !== 1'b1 || cpu_rst_n_o !== 1'b1 || err_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_reload done: done=%b cpu_rst_n=%b err=%b, required 1 1 0", done_o, cpu_rst_n_o, err_o);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 5; r++) begin
         random_image($urandom_range(1, DEPTH), $urandom_range(0, 3) == 0);
         stream_image(1'($urandom_range(0, 1)), -1);
         wait_end();
         vectors++;
         if (wr_addr_q.size() !== exp_addr_q.size()) begin
            miscompares++;
            $display("[TB] FAIL random %0d write_count: got %0d, required %0d", r, wr_addr_q.size(), exp_addr_q.size());
         end
         for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            vectors++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
               miscompares++;
               $display("[TB] FAIL random %0d write %0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                        r, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
            end
         end
         vectors++;
         if (done_o !== exp_ok || err_o !== !exp_ok || cpu_rst_n_o !== exp_ok ||
             (exp_ok ? done_cyc : err_cyc) !== exp_end_cyc) begin
            miscompares++;
            $display("[TB] FAIL random %0d flags: done=%b err=%b cpu_rst_n=%b end_cyc=%0d, required done=%b end_cyc=%0d",
                     r, done_o, err_o, cpu_rst_n_o, exp_ok ? done_cyc : err_cyc, exp_ok, exp_end_cyc);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_two_word();
      test_full_image();
      test_cksum_error();
      test_bad_header();
      test_gapped();
      test_reset_mid_data();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
